kamus_fetch: RTL and testbench

KAMUS_FETCH -- requirements
Module: kamus_fetch

---
 rtl/omer_pkg.sv | 18 +
 rtl/kamus_fetch_if.sv | 21 ++
 rtl/kamus_fetch_fifo.sv | 58 +++++
 rtl/kamus_fetch.sv | 129 ++++++++++++
 tb/tb_kamus_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/omer_pkg.sv
// Shared types and constants for the kamus instruction fetch stage.
package omer_pkg;

   localparam int unsigned XLEN              = 32;
   localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fetch_entry_t;

endpackage

// File: rtl/kamus_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
interface kamus_fetch_if;
   import omer_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i
   );

endinterface

// File: rtl/kamus_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, ins} entries with single-cycle flush.
module kamus_fetch_fifo
   import omer_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            i_flush,
   input  logic            i_push,
   input  logic            i_pop,
   input  fetch_entry_t    i_data,
   output fetch_entry_t    o_data,
   output logic [CW-1:0]   o_count,
   output logic            o_full,
   output logic            o_empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;

   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/kamus_fetch.sv
// Instruction fetch stage: one outstanding memory request, FIFO towards decode,
// redirect handling with discard of in-flight responses.
module kamus_fetch
   import omer_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   kamus_fetch_if.master     imem,
   output logic              ins_valid_o,
   output logic [31:0]       ins_o,
   output logic [31:0]       ins_pc_o,
   input  logic              ins_ready_i,
   output logic              misaligned_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OW = CW + 1;

   fetch_state_e  r_state;
   fetch_state_e  w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [31:0]   r_req_pc;
   logic [31:0]   w_req_pc_nxt;
   logic          r_misaligned;

   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_room;
   logic [CW-1:0] w_count;
   logic [OW-1:0] w_occ;
   logic [31:0]   w_redir_pc;
   fetch_entry_t  w_entry;
   fetch_entry_t  w_head;

   assign w_pop      = !w_empty && ins_ready_i;
   assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};
   assign w_entry    = '{pc: r_req_pc, ins: imem.imem_rdata_i};

   // A head entry leaving this cycle frees its slot for the request issued now.
   assign w_occ  = OW'(w_count) + OW'(r_state == WAIT) - OW'(w_pop);
   assign w_room = (w_occ < OW'(FIFO_DEPTH));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= FETCH;
         r_pc         <= BOOT_ADDR;
         r_req_pc     <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_req_pc     <= w_req_pc_nxt;
         r_misaligned <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_req        = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         FETCH: begin
            w_req = w_room && !redirect_i;
            if (redirect_i) begin
               w_pc_nxt = w_redir_pc;
            end else if (w_req && imem.imem_gnt_i) begin
               w_req_pc_nxt = r_pc;
               w_pc_nxt     = r_pc + 32'd4;
               w_state_nxt  = WAIT;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = imem.imem_rvalid_i ? FETCH : FLUSH;
            end else if (imem.imem_rvalid_i) begin
               w_push = 1'b1;
               w_req  = w_room;
               if (w_req && imem.imem_gnt_i) begin
                  w_req_pc_nxt = r_pc;
                  w_pc_nxt     = r_pc + 32'd4;
               end else begin
                  w_state_nxt  = FETCH;
               end
            end
         end
         FLUSH: begin
            if (redirect_i) w_pc_nxt = w_redir_pc;
            if (imem.imem_rvalid_i) w_state_nxt = FETCH;
         end
         default: w_state_nxt = FETCH;
      endcase
   end

   kamus_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_flush (redirect_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_entry),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign imem.imem_req_o  = w_req && rst_ni;
   assign imem.imem_addr_o = r_pc;
   assign ins_valid_o      = !w_empty;
   assign ins_o            = w_head.ins;
   assign ins_pc_o         = w_head.pc;
   assign misaligned_o     = r_misaligned;

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_kamus_fetch.sv
// Randomized scoreboard bench for kamus_fetch with a behavioural memory model.
module tb_kamus_fetch;
   import omer_pkg::*;

   localparam logic [31:0] BOOT = 32'h0000_0000;

   typedef enum int {SEL_REQ, SEL_ADDR, SEL_VALID, SEL_INS, SEL_PC, SEL_MIS,
                     SEL_TIMEOUT, SEL_WATCH} sel_e;
   typedef struct { sel_e sel; logic [31:0] exp; } dchk_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ins_ready;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        misaligned;

   kamus_fetch_if ifc ();

   kamus_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem          (ifc),
      .ins_valid_o   (ins_valid),
      .ins_o         (ins),
      .ins_pc_o      (ins_pc),
      .ins_ready_i   (ins_ready),
      .misaligned_o  (misaligned)
   );

   always #5 clk = ~clk;

   // Scoreboard and model state (monitor-owned unless noted)
   dchk_t       dir_q [$];     // directed checks, pushed by stimulus
   logic [31:0] nreq_q [$];    // expected addresses of the next requests
   logic [31:0] exp_q [$];     // expected in-order PC stream
   logic [31:0] exp_tail;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          watch_cnt = 0;
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt = 0;
   bit          mem_next_rv = 1'b0;
   bit          prev_req, prev_gnt, prev_valid, prev_ready, prev_redirect;
   logic [31:0] prev_addr, prev_rpc, prev_ins, prev_pc;
   dchk_t       d;
   logic [31:0] e;
   logic [31:0] act;

   // Stimulus-owned knobs
   int          gnt_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          dflt_ready = 1'b1;
   logic [31:0] watch_pc = 32'hFFFF_FFFF;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic string sel_name(input sel_e s);
      case (s)
         SEL_REQ:   return "imem_req";
         SEL_ADDR:  return "imem_addr";
         SEL_VALID: return "ins_valid";
         SEL_INS:   return "ins_o";
         SEL_PC:    return "ins_pc";
         SEL_MIS:   return "misaligned";
         SEL_WATCH: return "discarded_pc_emitted";
         default:   return "wait_timeout";
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
      n_tests++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, a, x, $time);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   // Monitor: directed checks, memory model, and in-order stream scoreboard.
   always @(negedge clk) begin
      while (dir_q.size() > 0) begin
         d = dir_q.pop_front();
         case (d.sel)
            SEL_REQ:   act = 32'(ifc.imem_req_o);
            SEL_ADDR:  act = ifc.imem_addr_o;
            SEL_VALID: act = 32'(ins_valid);
            SEL_INS:   act = ins;
            SEL_PC:    act = ins_pc;
            SEL_MIS:   act = 32'(misaligned);
            SEL_WATCH: act = 32'(watch_cnt);
            default:   act = 32'd0;
         endcase
         chk(sel_name(d.sel), act, d.exp);
      end

      if (ifc.imem_rvalid_i) mem_pend = 1'b0;
      if (ifc.imem_req_o && ifc.imem_gnt_i) begin
         chk("one_outstanding", 32'(mem_pend), 32'd0);
         mem_pend = 1'b1;
         mem_addr = ifc.imem_addr_o;
         mem_cnt  = int'($urandom_range(lat_max, lat_min));
      end

      if (!rst_n) begin
         exp_q.delete();
         exp_tail      = BOOT;
         prev_req      = 1'b0;
         prev_gnt      = 1'b0;
         prev_valid    = 1'b0;
         prev_ready    = 1'b0;
         prev_redirect = 1'b0;
         prev_rpc      = '0;
      end else begin
         if (ifc.imem_req_o) chk("addr_align", 32'(ifc.imem_addr_o[1:0]), 32'd0);
         if (prev_req && !prev_gnt && ifc.imem_req_o)
            chk("addr_hold", ifc.imem_addr_o, prev_addr);
         if (ifc.imem_req_o && nreq_q.size() > 0)
            chk("req_addr", ifc.imem_addr_o, nreq_q.pop_front());
         chk("misaligned_pulse", 32'(misaligned),
             32'(prev_redirect && (prev_rpc[1:0] != 2'b00)));
         if (prev_valid && !prev_ready && !prev_redirect && ins_valid) begin
            chk("ins_hold", ins, prev_ins);
            chk("pc_hold", ins_pc, prev_pc);
         end
         if (ins_valid && ins_ready) begin
            refill();
            e = exp_q.pop_front();
            chk("stream_pc", ins_pc, e);
            chk("stream_ins", ins, mem_word(e));
            if (ins_pc == watch_pc) watch_cnt++;
         end
         if (redirect) begin
            exp_q.delete();
            exp_tail = {redirect_pc[31:2], 2'b00};
         end
         refill();
         prev_req      = ifc.imem_req_o;
         prev_gnt      = ifc.imem_gnt_i;
         prev_addr     = ifc.imem_addr_o;
         prev_valid    = ins_valid;
         prev_ready    = ins_ready;
         prev_redirect = redirect;
         prev_rpc      = redirect_pc;
         prev_ins      = ins;
         prev_pc       = ins_pc;
      end

      if (mem_pend) begin
         mem_cnt     = mem_cnt - 1;
         mem_next_rv = (mem_cnt == 0);
      end else begin
         mem_next_rv = 1'b0;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      ifc.imem_gnt_i    = (int'($urandom_range(99, 0)) < gnt_pct);
      ifc.imem_rvalid_i = mem_next_rv;
      ifc.imem_rdata_i  = mem_next_rv ? mem_word(mem_addr) : $urandom();
      redirect          = 1'b0;
      redirect_pc       = $urandom();
      ins_ready         = dflt_ready;
   endtask

   task automatic push_chk(input sel_e s, input logic [31:0] x);
      dchk_t t;
      t.sel = s;
      t.exp = x;
      dir_q.push_back(t);
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
   endtask

   task automatic wait_grant(input logic [31:0] a, input bit any);
      bit hit = 1'b0;
      for (int n = 0; n < 60 && !hit; n++) begin
         cycle();
         @(negedge clk);
         hit = ifc.imem_req_o && ifc.imem_gnt_i && (any || ifc.imem_addr_o == a);
      end
      if (!hit) push_chk(SEL_TIMEOUT, 32'd1);
   endtask

   task automatic wait_nreq();
      for (int n = 0; n < 40 && nreq_q.size() > 0; n++) cycle();
      if (nreq_q.size() > 0) begin
         push_chk(SEL_TIMEOUT, 32'd1);
         nreq_q.delete();
      end
   endtask

   initial begin
      logic [31:0] r;
      int          w0;
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
      ifc.imem_gnt_i = 1'b0; ifc.imem_rvalid_i = 1'b0; ifc.imem_rdata_i = '0;

      // Reset values, first request, first-valid latency, full throughput
      repeat (3) cycle();
      push_chk(SEL_REQ, 0); push_chk(SEL_VALID, 0); push_chk(SEL_MIS, 0);
      push_chk(SEL_INS, 0); push_chk(SEL_PC, 0);
      cycle(); rst_n = 1'b1;
      push_chk(SEL_REQ, 1); push_chk(SEL_ADDR, BOOT); push_chk(SEL_VALID, 0);
      cycle(); push_chk(SEL_VALID, 0);
      repeat (8) begin cycle(); push_chk(SEL_VALID, 1); end

      // Decoder stall: FIFO fills, requests stop, head stays stable, then drains
      dflt_ready = 1'b0;
      repeat (6) cycle();
      repeat (3) begin cycle(); push_chk(SEL_REQ, 0); push_chk(SEL_VALID, 1); end
      dflt_ready = 1'b1;
      repeat (10) cycle();

      // Redirect while the request for 8 is outstanding
      lat_min = 2; lat_max = 2;
      cycle(); do_redirect(32'h0);
      wait_grant(32'h8, 1'b0);
      cycle(); do_redirect(32'h100);
      watch_pc = 32'h8; w0 = watch_cnt;
      push_chk(SEL_REQ, 0);
      nreq_q.push_back(32'h100);
      wait_nreq();
      repeat (10) cycle();
      push_chk(SEL_WATCH, 32'(w0));

      // Misaligned redirect target
      lat_min = 1; lat_max = 1;
      cycle(); do_redirect(32'h202); nreq_q.push_back(32'h200);
      cycle(); push_chk(SEL_MIS, 1);
      cycle(); push_chk(SEL_MIS, 0);
      wait_nreq();

      // PC wrap at the top of the address space
      cycle(); do_redirect(32'hFFFF_FFFC);
      nreq_q.push_back(32'hFFFF_FFFC); nreq_q.push_back(32'h0000_0000);
      wait_nreq();
      repeat (5) cycle();

      // Reset mid-WAIT with the response arriving just after reset
      lat_min = 2; lat_max = 2;
      wait_grant(32'h0, 1'b1);
      cycle(); rst_n = 1'b0;
      cycle(); rst_n = 1'b1;
      push_chk(SEL_VALID, 0); push_chk(SEL_INS, 0); push_chk(SEL_PC, 0);
      push_chk(SEL_MIS, 0); push_chk(SEL_REQ, 1); push_chk(SEL_ADDR, BOOT);
      repeat (10) cycle();

      // Randomized traffic
      gnt_pct = 70; lat_min = 1; lat_max = 3;
      repeat (3000) begin
         cycle();
         ins_ready = (int'($urandom_range(99, 0)) < 75);
         if ($urandom_range(99, 0) < 3) begin
            r = $urandom();
            if ($urandom_range(3, 0) != 0) r[1:0] = 2'b00;
            do_redirect(r);
         end
      end
      repeat (5) cycle();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2000000");
      $fatal(1, "watchdog expired");
   end

endmodule
